// File: rtl/dcache_assoc_if.sv
// Request/response bundle between the dcache array and its LSQ / DMEM-controller neighbours.
// master = cache client side, slave = dcache_assoc.
interface dcache_assoc_if #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned TAG_W    = 9,
    parameter int unsigned DATA_W   = 64
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    logic [NUM_RD*IDX_W-1:0]  rd_idx;
    logic [NUM_RD*TAG_W-1:0]  rd_tag;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;

    logic                     st_en;
    logic [IDX_W-1:0]         st_idx;
    logic [TAG_W-1:0]         st_tag;
    logic [DATA_W-1:0]        st_data;
    logic                     st_hit;

    logic                     fill_en;
    logic [IDX_W-1:0]         fill_idx;
    logic [TAG_W-1:0]         fill_tag;
    logic [DATA_W-1:0]        fill_data;
    logic                     fill_ready;

    logic                     evict_valid;
    logic                     evict_ready;
    logic [IDX_W-1:0]         evict_idx;
    logic [TAG_W-1:0]         evict_tag;
    logic [DATA_W-1:0]        evict_data;

    modport master (
        output rd_idx, rd_tag, st_en, st_idx, st_tag, st_data,
               fill_en, fill_idx, fill_tag, fill_data, evict_ready,
        input  rd_data, rd_valid, st_hit, fill_ready,
               evict_valid, evict_idx, evict_tag, evict_data
    );

    modport slave (
        input  rd_idx, rd_tag, st_en, st_idx, st_tag, st_data,
               fill_en, fill_idx, fill_tag, fill_data, evict_ready,
        output rd_data, rd_valid, st_hit, fill_ready,
               evict_valid, evict_idx, evict_tag, evict_data
    );
endinterface

// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache array: N read ports, store-on-hit, true-LRU fill, 1-entry eviction buffer.
// Optional: define DCACHE_READ_LRU_EN to let read hits update LRU state.
module dcache_assoc #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned TAG_W    = 9,
    parameter int unsigned DATA_W   = 64
) (
    input logic           clock,
    input logic           reset,
    dcache_assoc_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned WAY_W = AGE_W;

    typedef logic [NUM_WAYS-1:0][AGE_W-1:0] age_row_t;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    age_row_t            age_q   [NUM_SETS];
    age_row_t            age_n   [NUM_SETS];

    logic                evict_valid_q;
    logic [IDX_W-1:0]    evict_idx_q;
    logic [TAG_W-1:0]    evict_tag_q;
    logic [DATA_W-1:0]   evict_data_q;

    logic [IDX_W-1:0]    rd_idx_a [NUM_RD];
    logic [TAG_W-1:0]    rd_tag_a [NUM_RD];
    logic [NUM_RD-1:0]   rd_hit;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    logic                st_hit_c;
    logic [WAY_W-1:0]    st_way;

    logic                fill_hit;
    logic [WAY_W-1:0]    fill_hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    lru_way;
    logic [WAY_W-1:0]    victim;
    logic [WAY_W-1:0]    fill_way;
    logic                need_evict;
    logic                fill_ready_c;
    logic                push;

    // Move way to MRU; ways younger than it age by one.
    function automatic age_row_t touch(input age_row_t row, input logic [WAY_W-1:0] way);
        age_row_t res;
        res = row;
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (row[WAY_W'(i)] < row[way]) res[WAY_W'(i)] = row[WAY_W'(i)] + AGE_W'(1);
        end
        res[way] = '0;
        return res;
    endfunction

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd_split
        assign rd_idx_a[p] = bus.rd_idx[p*IDX_W +: IDX_W];
        assign rd_tag_a[p] = bus.rd_tag[p*TAG_W +: TAG_W];
    end

    // Combinational tag match on every read port; no bypass of this cycle's writes.
    always_comb begin
        rd_hit    = '0;
        rd_data_c = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
                if (valid_q[rd_idx_a[p]][WAY_W'(w)] &&
                    tag_q[rd_idx_a[p]][WAY_W'(w)] == rd_tag_a[p]) begin
                    rd_hit[p] = 1'b1;
                    rd_data_c[p*DATA_W +: DATA_W] = data_q[rd_idx_a[p]][WAY_W'(w)];
                end
            end
        end
    end

`ifdef DCACHE_READ_LRU_EN
    logic [WAY_W-1:0] rd_way [NUM_RD];

    always_comb begin
        for (int p = 0; p < int'(NUM_RD); p++) begin
            rd_way[p] = '0;
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
                if (valid_q[rd_idx_a[p]][WAY_W'(w)] &&
                    tag_q[rd_idx_a[p]][WAY_W'(w)] == rd_tag_a[p]) rd_way[p] = WAY_W'(w);
            end
        end
    end
`endif

    always_comb begin
        st_hit_c = 1'b0;
        st_way   = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (bus.st_en && valid_q[bus.st_idx][WAY_W'(w)] &&
                tag_q[bus.st_idx][WAY_W'(w)] == bus.st_tag) begin
                st_hit_c = 1'b1;
                st_way   = WAY_W'(w);
            end
        end
    end

    // Fill target: existing tag, else lowest invalid way, else the oldest way.
    always_comb begin
        fill_hit     = 1'b0;
        fill_hit_way = '0;
        inv_found    = 1'b0;
        inv_way      = '0;
        lru_way      = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[bus.fill_idx][WAY_W'(w)]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[bus.fill_idx][WAY_W'(w)] &&
                tag_q[bus.fill_idx][WAY_W'(w)] == bus.fill_tag) begin
                fill_hit     = 1'b1;
                fill_hit_way = WAY_W'(w);
            end
            if (age_q[bus.fill_idx][WAY_W'(w)] == AGE_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
        end
    end

    assign victim       = inv_found ? inv_way : lru_way;
    assign fill_way     = fill_hit ? fill_hit_way : victim;
    assign need_evict   = !fill_hit && valid_q[bus.fill_idx][victim] && dirty_q[bus.fill_idx][victim];
    assign fill_ready_c = bus.fill_en
                          && !(bus.st_en && bus.st_idx == bus.fill_idx)
                          && !(need_evict && evict_valid_q && !bus.evict_ready);
    assign push         = fill_ready_c && need_evict;

    // Touches are applied in order: read ports (optional), store, fill.
    always_comb begin
        age_n = age_q;
`ifdef DCACHE_READ_LRU_EN
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (rd_hit[p]) age_n[rd_idx_a[p]] = touch(age_n[rd_idx_a[p]], rd_way[p]);
        end
`endif
        if (st_hit_c)     age_n[bus.st_idx]   = touch(age_n[bus.st_idx], st_way);
        if (fill_ready_c) age_n[bus.fill_idx] = touch(age_n[bus.fill_idx], fill_way);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[IDX_W'(s)] <= '0;
                dirty_q[IDX_W'(s)] <= '0;
                for (int w = 0; w < int'(NUM_WAYS); w++) age_q[IDX_W'(s)][WAY_W'(w)] <= AGE_W'(w);
            end
            evict_valid_q <= 1'b0;
        end else begin
            age_q <= age_n;
            if (st_hit_c) dirty_q[bus.st_idx][st_way] <= 1'b1;
            if (fill_ready_c && !fill_hit) begin
                valid_q[bus.fill_idx][victim] <= 1'b1;
                dirty_q[bus.fill_idx][victim] <= 1'b0;
            end
            if (push)                 evict_valid_q <= 1'b1;
            else if (bus.evict_ready) evict_valid_q <= 1'b0;
        end
    end

    // Payload storage has no reset; the eviction payload survives reset untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (st_hit_c) data_q[bus.st_idx][st_way] <= bus.st_data;
            if (fill_ready_c) begin
                data_q[bus.fill_idx][fill_way] <= bus.fill_data;
                tag_q[bus.fill_idx][fill_way]  <= bus.fill_tag;
            end
            if (push) begin
                evict_idx_q  <= bus.fill_idx;
                evict_tag_q  <= tag_q[bus.fill_idx][victim];
                evict_data_q <= data_q[bus.fill_idx][victim];
            end
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_valid    = rd_hit;
    assign bus.st_hit      = st_hit_c;
    assign bus.fill_ready  = fill_ready_c;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_idx   = evict_idx_q;
    assign bus.evict_tag   = evict_tag_q;
    assign bus.evict_data  = evict_data_q;
endmodule

// File: tb/tb_dcache_assoc.sv
// Vector-table bench for dcache_assoc (16 sets, 2 ways, 2 read ports); expectations queued per driven cycle.
module tb_dcache_assoc;
    logic clock;
    logic reset;

    dcache_assoc_if #(.NUM_SETS(16), .NUM_RD(2), .TAG_W(9), .DATA_W(64)) bus ();

    dcache_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .NUM_RD(2), .TAG_W(9), .DATA_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic [3:0]  ri0;  logic [8:0] rt0;
        logic [3:0]  ri1;  logic [8:0] rt1;
        logic        se;   logic [3:0] si;  logic [8:0] stg; logic [63:0] sd;
        logic        fe;   logic [3:0] fi;  logic [8:0] ftg; logic [63:0] fd;
        logic        er;
    } stim_t;

    typedef struct packed {
        logic [1:0]  rv;
        logic [63:0] rd0;
        logic [63:0] rd1;
        logic        sth;
        logic        frdy;
        logic        ev;
        logic        chk_e;
        logic [3:0]  eidx;
        logic [8:0]  etag;
        logic [63:0] edata;
    } exp_t;

    typedef struct packed { stim_t s; exp_t e; } vec_t;

    vec_t  vecs[$];
    vec_t  cur;
    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    int    vec_no = 0;

    task automatic nv();
        cur = '0;
    endtask

    task automatic rd(input logic [3:0] i0, input logic [8:0] t0, input logic [3:0] i1, input logic [8:0] t1);
        cur.s.ri0 = i0; cur.s.rt0 = t0; cur.s.ri1 = i1; cur.s.rt1 = t1;
    endtask

    task automatic st(input logic [3:0] i, input logic [8:0] t, input logic [63:0] d);
        cur.s.se = 1'b1; cur.s.si = i; cur.s.stg = t; cur.s.sd = d;
    endtask

    task automatic fl(input logic [3:0] i, input logic [8:0] t, input logic [63:0] d);
        cur.s.fe = 1'b1; cur.s.fi = i; cur.s.ftg = t; cur.s.fd = d;
    endtask

    task automatic exe(input logic [3:0] i, input logic [8:0] t, input logic [63:0] d);
        cur.e.chk_e = 1'b1; cur.e.eidx = i; cur.e.etag = t; cur.e.edata = d;
    endtask

    // Closes the current vector and appends it to the table.
    task automatic ex(input logic [1:0] rv, input logic [63:0] d0, input logic [63:0] d1,
                      input logic sth, input logic frdy, input logic ev);
        cur.e.rv = rv; cur.e.rd0 = d0; cur.e.rd1 = d1;
        cur.e.sth = sth; cur.e.frdy = frdy; cur.e.ev = ev;
        vecs.push_back(cur);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL vec%0d %s: got %0h expected %0h", vec_no, name, act, req);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        chk("rd_valid",    64'(bus.rd_valid),      64'(e.rv));
        chk("rd_data0",    bus.rd_data[63:0],      e.rd0);
        chk("rd_data1",    bus.rd_data[127:64],    e.rd1);
        chk("st_hit",      64'(bus.st_hit),        64'(e.sth));
        chk("fill_ready",  64'(bus.fill_ready),    64'(e.frdy));
        chk("evict_valid", 64'(bus.evict_valid),   64'(e.ev));
        if (e.chk_e) begin
            chk("evict_idx",  64'(bus.evict_idx),  64'(e.eidx));
            chk("evict_tag",  64'(bus.evict_tag),  64'(e.etag));
            chk("evict_data", bus.evict_data,      e.edata);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clock);
        #1;
        reset           = v.s.rst;
        bus.rd_idx      = {v.s.ri1, v.s.ri0};
        bus.rd_tag      = {v.s.rt1, v.s.rt0};
        bus.st_en       = v.s.se;
        bus.st_idx      = v.s.si;
        bus.st_tag      = v.s.stg;
        bus.st_data     = v.s.sd;
        bus.fill_en     = v.s.fe;
        bus.fill_idx    = v.s.fi;
        bus.fill_tag    = v.s.ftg;
        bus.fill_data   = v.s.fd;
        bus.evict_ready = v.s.er;
        sb.push_back(v.e);
        @(negedge clock);
        compare_out();
        vec_no++;
    endtask

    initial begin
        reset = 1'b1;
        bus.rd_idx = '0; bus.rd_tag = '0;
        bus.st_en = 1'b0; bus.st_idx = '0; bus.st_tag = '0; bus.st_data = '0;
        bus.fill_en = 1'b0; bus.fill_idx = '0; bus.fill_tag = '0; bus.fill_data = '0;
        bus.evict_ready = 1'b0;
        repeat (2) @(posedge clock);

        // Reset state, fill visibility, no bypass
        nv(); rd(3, 9'h05, 3, 9'h05);                       ex(2'b00, 0, 0, 0, 0, 0);
        nv(); rd(3, 9'h05, 3, 9'h05); fl(3, 9'h05, 64'hAA); ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(3, 9'h05, 3, 9'h06);                       ex(2'b01, 64'hAA, 0, 0, 0, 0);
        // Set 1: A,B fill; store A; C replaces clean B; D evicts dirty A
        nv(); fl(1, 9'h0A, 64'hA0);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); fl(1, 9'h0B, 64'hB0);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(1, 9'h0A, 1, 9'h0B); st(1, 9'h0A, 64'h11); ex(2'b11, 64'hA0, 64'hB0, 1, 0, 0);
        nv(); rd(1, 9'h0B, 1, 9'h0A); fl(1, 9'h0C, 64'hC0); ex(2'b11, 64'hB0, 64'h11, 0, 1, 0);
        nv(); rd(1, 9'h0B, 1, 9'h0C); fl(1, 9'h0D, 64'hD0); ex(2'b10, 0, 64'hC0, 0, 1, 0);
        nv(); rd(1, 9'h0D, 1, 9'h0A); exe(1, 9'h0A, 64'h11); ex(2'b01, 64'hD0, 0, 0, 0, 1);
        // Make both ways dirty while the buffer is stalled
        nv(); st(1, 9'h0C, 64'h22);   exe(1, 9'h0A, 64'h11); ex(2'b00, 0, 0, 1, 0, 1);
        nv(); st(1, 9'h0D, 64'h33);   exe(1, 9'h0A, 64'h11); ex(2'b00, 0, 0, 1, 0, 1);
        // Fill needing dirty eviction is held off, then accepted on evict_ready
        nv(); rd(1, 9'h0C, 1, 9'h0E); fl(1, 9'h0E, 64'hE0); exe(1, 9'h0A, 64'h11); ex(2'b01, 64'h22, 0, 0, 0, 1);
        nv(); rd(1, 9'h0C, 1, 9'h0E); fl(1, 9'h0E, 64'hE0); exe(1, 9'h0A, 64'h11); ex(2'b01, 64'h22, 0, 0, 0, 1);
        nv(); rd(1, 9'h0C, 1, 9'h0E); fl(1, 9'h0E, 64'hE0); cur.s.er = 1'b1; exe(1, 9'h0A, 64'h11);
              ex(2'b01, 64'h22, 0, 0, 1, 1);
        nv(); rd(1, 9'h0E, 1, 9'h0C); exe(1, 9'h0C, 64'h22); ex(2'b01, 64'hE0, 0, 0, 0, 1);
        nv(); cur.s.er = 1'b1;        exe(1, 9'h0C, 64'h22); ex(2'b00, 0, 0, 0, 0, 1);
        nv();                                               ex(2'b00, 0, 0, 0, 0, 0);
        // Set 7: store/fill collision, store miss, fill-hit, dirty eviction
        nv(); fl(7, 9'h70, 64'h70);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); st(7, 9'h70, 64'h77); fl(7, 9'h71, 64'h71);   ex(2'b00, 0, 0, 1, 0, 0);
        nv(); st(7, 9'h72, 64'h99); rd(7, 9'h70, 7, 9'h71); ex(2'b01, 64'h77, 0, 0, 0, 0);
        nv(); fl(7, 9'h71, 64'h71); rd(7, 9'h72, 7, 9'h70); ex(2'b10, 0, 64'h77, 0, 1, 0);
        nv(); fl(7, 9'h73, 64'h73);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); fl(7, 9'h71, 64'h7171); cur.s.er = 1'b1; exe(7, 9'h70, 64'h77); ex(2'b00, 0, 0, 0, 1, 1);
        nv(); rd(7, 9'h71, 7, 9'h73);                       ex(2'b11, 64'h7171, 64'h73, 0, 0, 0);
        nv(); fl(7, 9'h74, 64'h74);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(7, 9'h73, 7, 9'h71);                       ex(2'b10, 0, 64'h7171, 0, 0, 0);
        // Set 2: read hit on A before fill C
        nv(); fl(2, 9'h0A, 64'h2A);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); fl(2, 9'h0B, 64'h2B);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(2, 9'h0A, 2, 9'h1FF);                      ex(2'b01, 64'h2A, 0, 0, 0, 0);
        nv(); fl(2, 9'h0C, 64'h2C);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(2, 9'h0A, 2, 9'h0B);
`ifdef DCACHE_READ_LRU_EN
        ex(2'b01, 64'h2A, 0, 0, 0, 0);
`else
        ex(2'b10, 0, 64'h2B, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Mid-operation reset: dirty line and valid buffer are dropped, buffer payload is held
        vecs.delete();
        nv(); fl(5, 9'h50, 64'h50);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); st(5, 9'h50, 64'h55);                         ex(2'b00, 0, 0, 1, 0, 0);
        nv(); fl(5, 9'h51, 64'h51);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); fl(5, 9'h52, 64'h52);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); cur.s.rst = 1'b1; rd(5, 9'h51, 5, 9'h50); exe(5, 9'h50, 64'h55); ex(2'b01, 64'h51, 0, 0, 0, 1);
        nv(); rd(5, 9'h51, 5, 9'h52); exe(5, 9'h50, 64'h55); ex(2'b00, 0, 0, 0, 0, 0);
        nv(); fl(5, 9'h60, 64'h60);                         ex(2'b00, 0, 0, 0, 1, 0);
        nv(); rd(5, 9'h60, 5, 9'h52);                       ex(2'b01, 64'h60, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
